// File: rtl/ape_stream_engine.sv
// ape_stream_engine: accumulates MPE partial sums over one ROWS x COLS output tile.
// The accumulators start from a broadcast bias. Each result is requantised, passed
// through the activation, optionally 2x2 pooled, and streamed out one row per
// valid/ready transfer.
module ape_stream_engine #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 8,
    parameter int FRAC_SH  = 0,
    parameter int CLIP_MAX = 6
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       bias_valid,
    input  logic signed [ACC_W-1:0]    bias,
    input  logic [1:0]                 af_type,
    input  logic [1:0]                 pool_type,
    input  logic                       acc_valid,
    input  logic                       acc_last,
    input  logic [ROWS*COLS*ACC_W-1:0] mpe_vals,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*OUT_W-1:0]      out_data,
    output logic                       busy,
    output logic                       done,
    output logic                       protocol_err
);

    localparam int N     = ROWS * COLS;
    localparam int CNT_W = (ROWS > 2) ? $clog2(ROWS) : 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN     = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] CLIP_ACC    = ACC_W'(CLIP_MAX);
    localparam logic signed [ACC_W-1:0] OUT_MAX_ACC = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN_ACC = ACC_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {IDLE, ACCUM, POST, DRAIN} state_t;

    state_t                  state, state_next;
    logic signed [ACC_W-1:0] acc  [N];
    logic signed [OUT_W-1:0] post [N];
    logic [1:0]              af_q;
    logic [1:0]              pool_q;
    logic [CNT_W-1:0]        row_idx;
    logic                    pooled;
    logic                    last_row;
    logic                    xfer;

    // Saturating add that clamps to the signed range of the accumulator
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        return s[ACC_W-1:0];
    endfunction

    // Requantise, apply the activation, then clamp to the signed output width
    function automatic logic signed [OUT_W-1:0] post_proc(input logic signed [ACC_W-1:0] a,
                                                          input logic [1:0] af);
        logic signed [ACC_W-1:0] v;
        v = a >>> FRAC_SH;
        if (af == 2'd1) begin
            if (v < 0) v = '0;
        end else if (af == 2'd2) begin
            if (v < 0) v = '0;
            else if (v > CLIP_ACC) v = CLIP_ACC;
        end
        if (v > OUT_MAX_ACC) v = OUT_MAX_ACC;
        else if (v < OUT_MIN_ACC) v = OUT_MIN_ACC;
        return v[OUT_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] max4(input logic signed [OUT_W-1:0] a, b, c, d);
        logic signed [OUT_W-1:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // The sum is kept two bits wider so it cannot overflow; the shift floors toward -inf
    function automatic logic signed [OUT_W-1:0] avg4(input logic signed [OUT_W-1:0] a, b, c, d);
        logic signed [OUT_W+1:0] s;
        s = (OUT_W+2)'(a) + (OUT_W+2)'(b) + (OUT_W+2)'(c) + (OUT_W+2)'(d);
        s = s >>> 2;
        return s[OUT_W-1:0];
    endfunction

    assign pooled   = (pool_q == 2'd1) || (pool_q == 2'd2);
    assign last_row = pooled ? (row_idx == CNT_W'(ROWS/2 - 1)) : (row_idx == CNT_W'(ROWS - 1));
    assign xfer     = out_valid && out_ready;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: bias starts a job, the last beat ends accumulation, the last row ends the drain
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bias_valid) state_next = ACCUM;
            ACCUM:   if (acc_valid && acc_last) state_next = POST;
            POST:    state_next = DRAIN;
            DRAIN:   if (xfer && last_row) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM status outputs
    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == DRAIN);
    end

    // Datapath: bias preload, saturating accumulation, post-processing, row counter, done and error flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                acc[i]  <= '0;
                post[i] <= '0;
            end
            af_q         <= '0;
            pool_q       <= '0;
            row_idx      <= '0;
            done         <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            done <= (state == DRAIN) && xfer && last_row;

            if ((acc_valid && state != ACCUM) || (bias_valid && state != IDLE))
                protocol_err <= 1'b1;
            else if (bias_valid && state == IDLE)
                protocol_err <= 1'b0;

            if (state == IDLE && bias_valid) begin
                af_q   <= af_type;
                pool_q <= pool_type;
                for (int i = 0; i < N; i++) acc[i] <= bias;
            end

            if (state == ACCUM && acc_valid) begin
                for (int i = 0; i < N; i++)
                    acc[i] <= sat_add(acc[i], $signed(mpe_vals[i*ACC_W +: ACC_W]));
            end

            if (state == POST) begin
                for (int i = 0; i < N; i++) post[i] <= post_proc(acc[i], af_q);
                row_idx <= '0;
            end

            if (state == DRAIN && xfer)
                row_idx <= row_idx + 1'b1;
        end
    end

    // Output row: either a plain post row or the pooled pair of rows; the row index only moves on a transfer
    always_comb begin
        int base;
        out_data = '0;
        base     = 0;
        if (state == DRAIN) begin
            if (pooled) begin
                base = 2 * int'(row_idx) * COLS;
                for (int j = 0; j < COLS/2; j++) begin
                    if (pool_q == 2'd1)
                        out_data[j*OUT_W +: OUT_W] = max4(post[base + 2*j], post[base + 2*j + 1],
                                                          post[base + COLS + 2*j],
                                                          post[base + COLS + 2*j + 1]);
                    else
                        out_data[j*OUT_W +: OUT_W] = avg4(post[base + 2*j], post[base + 2*j + 1],
                                                          post[base + COLS + 2*j],
                                                          post[base + COLS + 2*j + 1]);
                end
            end else begin
                base = int'(row_idx) * COLS;
                for (int c = 0; c < COLS; c++)
                    out_data[c*OUT_W +: OUT_W] = post[base + c];
            end
        end
    end

endmodule

// File: tb/tb_ape_stream_engine.sv
// Testbench for ape_stream_engine. Expected rows are queued as each job is issued,
// and an independent monitor pops and compares them on every transfer.
module tb_ape_stream_engine;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int MPE_W = ROWS * COLS * ACC_W;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    bias_valid;
    logic signed [ACC_W-1:0] bias;
    logic [1:0]              af_type;
    logic [1:0]              pool_type;
    logic                    acc_valid;
    logic                    acc_last;
    logic [MPE_W-1:0]        mpe_vals;
    logic                    out_valid;
    logic                    out_ready;
    logic [COLS*OUT_W-1:0]   out_data;
    logic                    busy;
    logic                    done;
    logic                    protocol_err;

    int total = 0;
    int bad = 0;
    int rows_seen = 0;
    int base;
    int m[16];
    logic [COLS*OUT_W-1:0] exp_q[$];

    ape_stream_engine dut (
        .clock(clock), .reset(reset),
        .bias_valid(bias_valid), .bias(bias), .af_type(af_type), .pool_type(pool_type),
        .acc_valid(acc_valid), .acc_last(acc_last), .mpe_vals(mpe_vals),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .protocol_err(protocol_err)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic bv, input logic [31:0] b, input logic [1:0] af,
                                 input logic [1:0] pool, input logic av, input logic al,
                                 input logic [MPE_W-1:0] mpe);
        bias_valid = bv; bias = b; af_type = af; pool_type = pool;
        acc_valid = av; acc_last = al; mpe_vals = mpe;
        tick();
        bias_valid = 1'b0; acc_valid = 1'b0; acc_last = 1'b0;
    endtask

    function automatic logic [MPE_W-1:0] fill_all(input int v);
        logic [MPE_W-1:0] r;
        for (int i = 0; i < ROWS*COLS; i++) r[i*ACC_W +: ACC_W] = v;
        return r;
    endfunction

    function automatic logic [MPE_W-1:0] pack(input int a[16]);
        logic [MPE_W-1:0] r;
        for (int i = 0; i < ROWS*COLS; i++) r[i*ACC_W +: ACC_W] = a[i];
        return r;
    endfunction

    function automatic logic [COLS*OUT_W-1:0] row4(input int l0, input int l1, input int l2, input int l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        checkOutput({name, " done seen"}, done, 1);
        checkOutput({name, " queue drained"}, exp_q.size(), 0);
        tick();
        checkOutput({name, " done one cycle"}, done, 0);
        checkOutput({name, " idle busy"}, busy, 0);
    endtask

    // Scoreboard monitor: one expected row per accepted transfer
    always @(negedge clock) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            rows_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected row: got %0h expected none", out_data);
            end else begin
                checkOutput("row", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; bias_valid = 1'b0; bias = '0; af_type = '0; pool_type = '0;
        acc_valid = 1'b0; acc_last = 1'b0; mpe_vals = '0; out_ready = 1'b0;
        #12;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset err", protocol_err, 0);
        checkOutput("reset out_data", out_data, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        tick();

        // stray beat in IDLE
        applyStimulus(0, 0, 0, 0, 1, 1, fill_all(1));
        checkOutput("idle acc err", protocol_err, 1);
        checkOutput("idle acc busy", busy, 0);

        // test 1: bias 5 + 3 - 1 = 7 everywhere
        $display("[TB] test 1 plain rows");
        out_ready = 1'b1;
        applyStimulus(1, 5, 0, 0, 0, 0, '0);
        checkOutput("t1 busy", busy, 1);
        checkOutput("t1 err cleared", protocol_err, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, fill_all(3));
        for (int i = 0; i < 4; i++) exp_q.push_back(row4(7, 7, 7, 7));
        base = rows_seen;
        applyStimulus(0, 0, 0, 0, 1, 1, fill_all(-1));
        checkOutput("t1 post no valid", out_valid, 0);
        tick();
        checkOutput("t1 first valid", out_valid, 1);
        wait_done("t1", 20);
        checkOutput("t1 row count", rows_seen - base, 4);

        // test 2: ReLU + max pool; a mid-job bias is ignored
        $display("[TB] test 2 relu max pool");
        m = '{-4, 2, -1, -2,  9, -1, -3, -4,  1, 2, 10, -5,  3, 4, 0, 7};
        applyStimulus(1, 0, 1, 1, 0, 0, '0);
        applyStimulus(1, 0, 0, 0, 0, 0, '0);
        checkOutput("t2 mid bias err", protocol_err, 1);
        exp_q.push_back(row4(9, 0, 0, 0));
        exp_q.push_back(row4(4, 10, 0, 0));
        base = rows_seen;
        applyStimulus(0, 0, 0, 0, 1, 1, pack(m));
        wait_done("t2", 20);
        checkOutput("t2 row count", rows_seen - base, 2);

        // test 3: average pool with floor
        $display("[TB] test 3 avg pool");
        m = '{1, 2, -1, -2,  3, 5, -3, -5,  0, 0, 7, 7,  0, 1, 7, 8};
        applyStimulus(1, 0, 0, 2, 0, 0, '0);
        checkOutput("t3 err cleared", protocol_err, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, pack(m));
        exp_q.push_back(row4(2, -3, 0, 0));
        exp_q.push_back(row4(0, 7, 0, 0));
        applyStimulus(0, 0, 0, 0, 1, 1, fill_all(0));
        wait_done("t3", 20);

        // test 4: saturation and clamp activation
        $display("[TB] test 4 saturation");
        applyStimulus(1, 32'h7FFF_FFFF, 0, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) exp_q.push_back(row4(127, 127, 127, 127));
        applyStimulus(0, 0, 0, 0, 1, 1, fill_all(1));
        wait_done("t4a", 20);
        applyStimulus(1, 32'hFFFF_FFFF, 0, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) exp_q.push_back(row4(-128, -128, -128, -128));
        applyStimulus(0, 0, 0, 0, 1, 1, fill_all(int'(32'h8000_0000)));
        wait_done("t4b", 20);
        m = '{9, 9, 9, 9,  -3, -3, -3, -3,  4, 4, 4, 4,  6, 6, 6, 6};
        applyStimulus(1, 0, 2, 0, 0, 0, '0);
        exp_q.push_back(row4(6, 6, 6, 6));
        exp_q.push_back(row4(0, 0, 0, 0));
        exp_q.push_back(row4(4, 4, 4, 4));
        exp_q.push_back(row4(6, 6, 6, 6));
        applyStimulus(0, 0, 0, 0, 1, 1, pack(m));
        wait_done("t4c", 20);

        // test 5: backpressure hold and a stray beat during the drain
        $display("[TB] test 5 backpressure");
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) m[r*4 + c] = 16*r + c;
        applyStimulus(1, 0, 0, 0, 0, 0, '0);
        for (int r = 0; r < 4; r++) exp_q.push_back(row4(16*r, 16*r + 1, 16*r + 2, 16*r + 3));
        applyStimulus(0, 0, 0, 0, 1, 1, pack(m));
        tick();
        tick();
        out_ready = 1'b0;
        checkOutput("t5 err before", protocol_err, 0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t5 hold valid", out_valid, 1);
            checkOutput("t5 hold data", out_data, 32'h1312_1110);
            if (k == 0) applyStimulus(0, 0, 0, 0, 1, 0, fill_all(50));
            else tick();
        end
        checkOutput("t5 drain acc err", protocol_err, 1);
        out_ready = 1'b1;
        wait_done("t5", 20);

        // test 6: asynchronous reset mid-drain, then a clean job
        $display("[TB] test 6 reset mid drain");
        applyStimulus(1, 0, 0, 0, 0, 0, '0);
        for (int r = 0; r < 4; r++) exp_q.push_back(row4(16*r, 16*r + 1, 16*r + 2, 16*r + 3));
        applyStimulus(0, 0, 0, 0, 1, 1, pack(m));
        tick();
        tick();
        out_ready = 1'b0;
        applyStimulus(0, 0, 0, 0, 1, 0, fill_all(1));
        checkOutput("t6 err before reset", protocol_err, 1);
        reset = 1'b0;
        #1;
        checkOutput("t6 reset valid", out_valid, 0);
        checkOutput("t6 reset busy", busy, 0);
        checkOutput("t6 reset data", out_data, 0);
        checkOutput("t6 reset err", protocol_err, 0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        applyStimulus(1, 2, 0, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) exp_q.push_back(row4(3, 3, 3, 3));
        base = rows_seen;
        applyStimulus(0, 0, 0, 0, 1, 1, fill_all(1));
        wait_done("t6", 20);
        checkOutput("t6 row count", rows_seen - base, 4);
        checkOutput("t6 err clean", protocol_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
